// File: rtl/scalar_mult_ctrl.sv
// rtl/scalar_mult_ctrl.sv - left-to-right double-and-add sequencer driving one PointAdd unit
//
// Computes k*P by scanning the scalar MSB-first and issuing initial / double / add
// operations to an external PointAdd unit.
//
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_start, i_scalar, i_x, i_y         request, scalar k and affine base point
//   o_busy, o_done, o_err               status; o_err flags k == 0
//   o_x, o_y, o_z, o_t                  result registers (PointAdd representation)
//   o_pa_start, o_pa_doubling,
//   o_pa_initial                        PointAdd start pulse and mode
//   o_pa_x1..o_pa_t1, o_pa_x2..o_pa_t2  PointAdd operands
//   i_pa_x3..i_pa_t3, i_pa_finished     PointAdd results and completion pulse
//
// Option: SCALAR_MULT_CONST_TIME_EN makes the scan length and the add schedule
// independent of the scalar bit values.

module scalar_mult_ctrl #(
    parameter int SCALAR_W = 255,
    parameter int COORD_W  = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [SCALAR_W-1:0] i_scalar,
    input  logic [COORD_W-1:0]  i_x,
    input  logic [COORD_W-1:0]  i_y,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [COORD_W-1:0]  o_x,
    output logic [COORD_W-1:0]  o_y,
    output logic [COORD_W-1:0]  o_z,
    output logic [COORD_W-1:0]  o_t,
    output logic                o_pa_start,
    output logic                o_pa_doubling,
    output logic                o_pa_initial,
    output logic [COORD_W-1:0]  o_pa_x1,
    output logic [COORD_W-1:0]  o_pa_y1,
    output logic [COORD_W-1:0]  o_pa_z1,
    output logic [COORD_W-1:0]  o_pa_t1,
    output logic [COORD_W-1:0]  o_pa_x2,
    output logic [COORD_W-1:0]  o_pa_y2,
    output logic [COORD_W-1:0]  o_pa_z2,
    output logic [COORD_W-1:0]  o_pa_t2,
    input  logic [COORD_W-1:0]  i_pa_x3,
    input  logic [COORD_W-1:0]  i_pa_y3,
    input  logic [COORD_W-1:0]  i_pa_z3,
    input  logic [COORD_W-1:0]  i_pa_t3,
    input  logic                i_pa_finished
);

    localparam int CNT_W = $clog2(SCALAR_W);

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN, S_INIT, S_INIT_W, S_DBL, S_DBL_W, S_ADD, S_ADD_W, S_DONE
    } state_t;

    state_t state, next_state;

    logic [SCALAR_W-1:0] k_sr;
    logic [CNT_W-1:0]    cnt;
    logic                err_q;
    logic [COORD_W-1:0]  p_x, p_y, p_z, p_t;
    logic [COORD_W-1:0]  r_x, r_y, r_z, r_t;
    logic                k_msb;

`ifdef SCALAR_MULT_CONST_TIME_EN
    logic [CNT_W-1:0]    scan_cnt;
    logic                found;
    logic                add_bit;
`endif

    assign k_msb = k_sr[SCALAR_W-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        o_pa_start    = 1'b0;
        o_pa_doubling = 1'b0;
        o_pa_initial  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    next_state = (i_scalar == '0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
`ifdef SCALAR_MULT_CONST_TIME_EN
                if (scan_cnt == '0) next_state = S_INIT;
`else
                if (k_msb) next_state = S_INIT;
`endif
            end
            S_INIT: begin
                o_pa_start   = 1'b1;
                o_pa_initial = 1'b1;
                next_state   = S_INIT_W;
            end
            S_INIT_W: begin
                if (i_pa_finished) next_state = (cnt == '0) ? S_DONE : S_DBL;
            end
            S_DBL: begin
                o_pa_start    = 1'b1;
                o_pa_doubling = 1'b1;
                next_state    = S_DBL_W;
            end
            S_DBL_W: begin
                if (i_pa_finished) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
                    next_state = S_ADD;
`else
                    // cnt is decremented on this same edge, so test the post-decrement value
                    if (k_msb)                    next_state = S_ADD;
                    else if (cnt == CNT_W'(1))    next_state = S_DONE;
                    else                          next_state = S_DBL;
`endif
                end
            end
            S_ADD: begin
                o_pa_start = 1'b1;
                next_state = S_ADD_W;
            end
            S_ADD_W: begin
                if (i_pa_finished) next_state = (cnt == '0) ? S_DONE : S_DBL;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operand 1 is the raw affine point lifted to (x, y, 1, 0) for the initial
    // conversion, and the accumulator otherwise. Operand 2 is always the base.
    assign o_pa_x1 = (state == S_INIT) ? p_x : r_x;
    assign o_pa_y1 = (state == S_INIT) ? p_y : r_y;
    assign o_pa_z1 = (state == S_INIT) ? COORD_W'(1) : r_z;
    assign o_pa_t1 = (state == S_INIT) ? '0 : r_t;
    assign o_pa_x2 = p_x;
    assign o_pa_y2 = p_y;
    assign o_pa_z2 = p_z;
    assign o_pa_t2 = p_t;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k_sr   <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            p_x    <= '0;
            p_y    <= '0;
            p_z    <= '0;
            p_t    <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_t    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_err  <= 1'b0;
            o_x    <= '0;
            o_y    <= '0;
            o_z    <= '0;
            o_t    <= '0;
`ifdef SCALAR_MULT_CONST_TIME_EN
            scan_cnt <= '0;
            found    <= 1'b0;
            add_bit  <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        k_sr   <= i_scalar;
                        p_x    <= i_x;
                        p_y    <= i_y;
                        p_z    <= '0;
                        p_t    <= '0;
                        cnt    <= CNT_W'(SCALAR_W - 1);
                        err_q  <= (i_scalar == '0);
                        o_err  <= 1'b0;
                        o_busy <= 1'b1;
`ifdef SCALAR_MULT_CONST_TIME_EN
                        scan_cnt <= CNT_W'(SCALAR_W - 1);
                        found    <= 1'b0;
`endif
                    end
                end
                S_SCAN: begin
`ifdef SCALAR_MULT_CONST_TIME_EN
                    // Shift until the leading one has been consumed, then idle out
                    // the rest of the fixed-length window.
                    scan_cnt <= scan_cnt - CNT_W'(1);
                    if (!found) begin
                        k_sr <= k_sr << 1;
                        if (k_msb) found <= 1'b1;
                        else       cnt   <= cnt - CNT_W'(1);
                    end
`else
                    // The leading one is consumed by the initial operation.
                    k_sr <= k_sr << 1;
                    if (!k_msb) cnt <= cnt - CNT_W'(1);
`endif
                end
                S_INIT_W: begin
                    if (i_pa_finished) begin
                        p_x <= i_pa_x3;
                        p_y <= i_pa_y3;
                        p_z <= i_pa_z3;
                        p_t <= i_pa_t3;
                        r_x <= i_pa_x3;
                        r_y <= i_pa_y3;
                        r_z <= i_pa_z3;
                        r_t <= i_pa_t3;
                    end
                end
                S_DBL_W: begin
                    if (i_pa_finished) begin
                        r_x  <= i_pa_x3;
                        r_y  <= i_pa_y3;
                        r_z  <= i_pa_z3;
                        r_t  <= i_pa_t3;
                        cnt  <= cnt - CNT_W'(1);
                        k_sr <= k_sr << 1;
`ifdef SCALAR_MULT_CONST_TIME_EN
                        add_bit <= k_msb;
`endif
                    end
                end
                S_ADD_W: begin
`ifdef SCALAR_MULT_CONST_TIME_EN
                    // A zero bit still runs the add; its result is dropped.
                    if (i_pa_finished && add_bit) begin
`else
                    if (i_pa_finished) begin
`endif
                        r_x <= i_pa_x3;
                        r_y <= i_pa_y3;
                        r_z <= i_pa_z3;
                        r_t <= i_pa_t3;
                    end
                end
                S_DONE: begin
                    o_x    <= err_q ? '0 : r_x;
                    o_y    <= err_q ? '0 : r_y;
                    o_z    <= err_q ? '0 : r_z;
                    o_t    <= err_q ? '0 : r_t;
                    o_err  <= err_q;
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
